deser_16_64: RTL and testbench

Deserialiser from 16-bit to 64-bit: gathers four consecutive 16-bit words from the narrow link into one 64-bit word and presents it downstream with valid/stop flow control. It sits directly downstream of the 64-to-16 serialiser, on the receive side of the same link, and restores the original 64-bit word stream. Its valid/stop protocol is the same as the serialiser's: stop means "cannot accept".

---
 rtl/deser_16_64_pkg.sv | 11 +
 rtl/deser_16_64.sv | 69 ++++++
 tb/tb_deser_16_64.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/deser_16_64_pkg.sv
// Link constants shared by the 64-to-16 serialiser and
// the 16-to-64 deserialiser on the two ends of the link.
package deser_16_64_pkg;

  localparam int NARROW_W = 16;
  localparam int WIDE_W   = 64;
  localparam int RATIO    = 4;
  localparam int CNT_W    = 2;
  localparam int ASM_W    = WIDE_W - NARROW_W;

endpackage

// File: rtl/deser_16_64.sv
// Gathers four 16-bit link words, LSB word first, into one
// 64-bit word, with valid/stop flow control on both sides.
module deser_16_64
  import deser_16_64_pkg::*;
(
  input  logic                clk,
  input  logic                res_n,
  input  logic                valid_in,
  output logic                stop_out,
  input  logic [NARROW_W-1:0] data_in,
  output logic                valid_out,
  input  logic                stop_in,
  output logic [WIDE_W-1:0]   data_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ASM_W-1:0] asm;
  logic             acc;
  logic             cons;
  logic             last;
  logic             valid_nxt;
  logic             stop_nxt;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(RATIO - 1);

  always_comb begin
    acc       = valid_in && !stop_out;
    cons      = valid_out && !stop_in;
    last      = acc && (cnt == CNT_LAST);
    cnt_nxt   = cnt;
    valid_nxt = valid_out;
    if (acc)
      cnt_nxt = cnt + CNT_W'(1);
    if (last)
      valid_nxt = 1'b1;
    else if (cons)
      valid_nxt = 1'b0;
    // stall looks at the post-edge state
    stop_nxt = (cnt_nxt == CNT_LAST) && valid_nxt;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt <= '0;
      asm <= '0;
    end else if (acc) begin
      cnt <= cnt_nxt;
      for (int i = 0; i < RATIO - 1; i++)
        if (cnt == CNT_W'(i))
          asm[i*NARROW_W +: NARROW_W] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      stop_out  <= 1'b0;
    end else begin
      if (last)
        data_out <= {data_in, asm};
      valid_out <= valid_nxt;
      stop_out  <= stop_nxt;
    end
  end

endmodule

// File: tb/tb_deser_16_64.sv
// Directed and randomized checks of the 16-to-64
// deserialiser against hand-computed words and a queue.
module tb_deser_16_64;

  logic        clk;
  logic        res_n;
  logic        valid_in;
  logic        stop_out;
  logic [15:0] data_in;
  logic        valid_out;
  logic        stop_in;
  logic [63:0] data_out;

  int vectors;
  int miscompares;

  logic [63:0] expq[$];
  logic [15:0] part[$];

  deser_16_64 dut (
    .clk       (clk),
    .res_n     (res_n),
    .valid_in  (valid_in),
    .stop_out  (stop_out),
    .data_in   (data_in),
    .valid_out (valid_out),
    .stop_in   (stop_in),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v,
                     input logic [15:0] d,
                     input logic s);
    valid_in = v;
    data_in  = d;
    stop_in  = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] w4(
    input int a, input int b,
    input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  initial begin
    logic [63:0] held;
    logic        acc, cons, stall;
    logic [63:0] prev;

    vectors     = 0;
    miscompares = 0;
    res_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    stop_in  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_stop", 64'(stop_out), 64'd0);
    chk("rst_data", data_out, 64'd0);
    res_n = 1'b1;

    // basic word
    cyc(1, 16'h1111, 0);
    chk("basic_v0", 64'(valid_out), 64'd0);
    cyc(1, 16'h2222, 0);
    chk("basic_v1", 64'(valid_out), 64'd0);
    cyc(1, 16'h3333, 0);
    chk("basic_v2", 64'(valid_out), 64'd0);
    chk("basic_s2", 64'(stop_out), 64'd0);
    cyc(1, 16'h4444, 0);
    chk("basic_v3", 64'(valid_out), 64'd1);
    chk("basic_d", data_out,
        64'h4444_3333_2222_1111);
    chk("basic_s3", 64'(stop_out), 64'd0);
    cyc(0, 16'h0, 0);
    chk("basic_vend", 64'(valid_out), 64'd0);
    chk("basic_send", 64'(stop_out), 64'd0);

    // streaming
    for (int i = 0; i < 16; i++) begin
      cyc(1, 16'(i), 0);
      if (i % 4 == 3) begin
        chk("stream_v", 64'(valid_out), 64'd1);
        chk("stream_d", data_out,
            w4(i - 3, i - 2, i - 1, i));
      end else begin
        chk("stream_v0", 64'(valid_out), 64'd0);
      end
      chk("stream_s", 64'(stop_out), 64'd0);
    end
    cyc(0, 16'h0, 0);

    // input gaps
    cyc(1, 16'h1111, 0);
    cyc(0, 16'hdead, 0);
    cyc(0, 16'hbeef, 0);
    cyc(1, 16'h2222, 0);
    cyc(0, 16'hdead, 0);
    cyc(1, 16'h3333, 0);
    chk("gap_v0", 64'(valid_out), 64'd0);
    cyc(0, 16'hdead, 0);
    cyc(1, 16'h4444, 0);
    chk("gap_v", 64'(valid_out), 64'd1);
    chk("gap_d", data_out,
        64'h4444_3333_2222_1111);
    cyc(0, 16'h0, 0);
    chk("gap_vend", 64'(valid_out), 64'd0);

    // downstream stall
    for (int i = 0; i < 4; i++)
      cyc(1, 16'(16'h100 + i), 1);
    held = 64'h0103_0102_0101_0100;
    chk("stall_v1", 64'(valid_out), 64'd1);
    chk("stall_d1", data_out, held);
    chk("stall_s4", 64'(stop_out), 64'd0);
    cyc(1, 16'h104, 1);
    chk("stall_s5", 64'(stop_out), 64'd0);
    cyc(1, 16'h105, 1);
    chk("stall_s6", 64'(stop_out), 64'd0);
    chk("stall_h6", data_out, held);
    cyc(1, 16'h106, 1);
    chk("stall_s7", 64'(stop_out), 64'd1);
    chk("stall_h7", data_out, held);
    cyc(1, 16'h107, 1);
    cyc(1, 16'h107, 1);
    chk("stall_s8", 64'(stop_out), 64'd1);
    chk("stall_vh", 64'(valid_out), 64'd1);
    chk("stall_h8", data_out, held);
    cyc(1, 16'h107, 0);
    chk("stall_cons", 64'(valid_out), 64'd0);
    chk("stall_sfall", 64'(stop_out), 64'd0);
    cyc(1, 16'h107, 0);
    chk("stall_v2", 64'(valid_out), 64'd1);
    chk("stall_d2", data_out,
        64'h0107_0106_0105_0104);
    cyc(0, 16'h0, 0);
    chk("stall_vend", 64'(valid_out), 64'd0);

    // reset mid-assembly, data_out still nonzero
    cyc(1, 16'h00aa, 0);
    cyc(1, 16'h00bb, 0);
    #2 res_n = 1'b0;
    #1;
    chk("mrst_v", 64'(valid_out), 64'd0);
    chk("mrst_s", 64'(stop_out), 64'd0);
    chk("mrst_d", data_out, 64'd0);
    #1 res_n = 1'b1;
    cyc(1, 16'h000a, 0);
    cyc(1, 16'h000b, 0);
    cyc(1, 16'h000c, 0);
    chk("mrst_v0", 64'(valid_out), 64'd0);
    cyc(1, 16'h000d, 0);
    chk("mrst_v1", 64'(valid_out), 64'd1);
    chk("mrst_d1", data_out,
        64'h000d_000c_000b_000a);
    cyc(0, 16'h0, 0);

    // random traffic against a reference queue
    valid_in = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(valid_in && stop_out)) begin
        valid_in = ($urandom % 4) != 0;
        data_in  = 16'($urandom);
      end
      stop_in = ($urandom % 3) == 0;
      acc   = valid_in && !stop_out;
      cons  = valid_out && !stop_in;
      stall = valid_out && stop_in;
      prev  = data_out;
      if (cons) begin
        if (expq.size() == 0) begin
          chk("rnd_spurious", 64'(valid_out), 64'd0);
        end else begin
          chk("rnd_order", data_out, expq[0]);
          void'(expq.pop_front());
        end
      end
      if (acc) begin
        part.push_back(data_in);
        if (part.size() == 4) begin
          expq.push_back({part[3], part[2],
                          part[1], part[0]});
          part.delete();
        end
      end
      @(posedge clk);
      #1;
      if (stall) begin
        chk("rnd_hold_v", 64'(valid_out), 64'd1);
        chk("rnd_hold_d", data_out, prev);
      end
    end
    valid_in = 1'b0;
    stop_in  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (valid_out) begin
        if (expq.size() == 0) begin
          chk("rnd_extra", 64'(valid_out), 64'd0);
        end else begin
          chk("rnd_drain", data_out, expq[0]);
          void'(expq.pop_front());
        end
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_left", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
